// File: rtl/pc_next_unit.sv
// rtl/pc_next_unit.sv - Beta program counter with next-address selection and interrupt arbitration
// Optional sticky interrupt latch: define PCNEXT_IRQ_LATCH_EN (default build samples IRQ as a level).
module pc_next_unit #(
    parameter int unsigned     W         = 32,
    parameter int unsigned     LIT_W     = 16,
    parameter logic [W-1:0]    RESET_VEC = W'(32'h8000_0000),
    parameter logic [W-1:0]    ILLOP_VEC = W'(32'h8000_0004),
    parameter logic [W-1:0]    XADR_VEC  = W'(32'h8000_0008)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [2:0]       pcsel_i,
    input  logic [LIT_W-1:0] lit_i,
    input  logic [W-1:0]     jt_i,
    input  logic             irq_i,
    output logic [W-1:0]     pc_o,
    output logic [W-1:0]     pc4_o,
    output logic [W-1:0]     pc4sxt_o,
    output logic             irq_taken_o,
    output logic             exc_o
);

    localparam logic [W-1:0] LOW_MASK = ~W'(3);

    logic [W-1:0] pc_q;
    logic [W-1:0] pc_d;
    logic [W-1:0] sel_pc;
    logic [W-1:0] jt_tgt;
    logic [W-2:0] pc_inc;
    logic [W-2:0] br_off;
    logic [W-2:0] br_sum;
    logic         sup;
    logic         irq_pending;
    logic         irq_sel;
    logic         take_irq;
    logic         exc_sel;

    assign sup = pc_q[W-1];

    // Arithmetic runs on the low W-1 bits only so the supervisor bit never changes by carry.
    assign pc_inc = pc_q[W-2:0] + (W-1)'(4);
    assign br_off = {{(W-LIT_W-3){lit_i[LIT_W-1]}}, lit_i, 2'b00};
    assign br_sum = pc_inc + br_off;

    assign pc4_o    = {sup, pc_inc};
    assign pc4sxt_o = {sup, br_sum};
    assign jt_tgt   = {sup & jt_i[W-1], jt_i[W-2:0]};
    assign pc_o     = pc_q;

`ifdef PCNEXT_IRQ_LATCH_EN
    logic irq_pend_q;
    logic irq_prev_q;

    assign irq_pending = irq_pend_q;

    // A fresh rising edge wins over the clear so a back-to-back request is not dropped.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            irq_pend_q <= 1'b0;
            irq_prev_q <= 1'b0;
        end else begin
            irq_prev_q <= irq_i;
            irq_pend_q <= (irq_pend_q & ~take_irq) | (irq_i & ~irq_prev_q);
        end
    end
`else
    assign irq_pending = irq_i;
`endif

    assign irq_sel     = irq_pending & ~sup;
    assign take_irq    = irq_sel & en_i & ~rst_i;
    assign irq_taken_o = take_irq;

    always_comb begin
        sel_pc  = ILLOP_VEC;
        exc_sel = 1'b1;
        if (irq_sel) begin
            sel_pc = XADR_VEC;
        end else begin
            case (pcsel_i)
                3'b000:  begin sel_pc = pc4_o;    exc_sel = 1'b0; end
                3'b001:  begin sel_pc = pc4sxt_o; exc_sel = 1'b0; end
                3'b010:  begin sel_pc = jt_tgt;   exc_sel = 1'b0; end
                3'b100:  sel_pc = XADR_VEC;
                default: sel_pc = ILLOP_VEC;
            endcase
        end
    end

    assign exc_o = exc_sel & ~rst_i;
    assign pc_d  = sel_pc & LOW_MASK;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q <= RESET_VEC;
        end else if (en_i) begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: tb/tb_pc_next_unit.sv
// tb/tb_pc_next_unit.sv - randomized and directed self-checking bench for pc_next_unit
module tb_pc_next_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [2:0]  pcsel;
    logic [15:0] lit;
    logic [31:0] jt;
    logic        irq;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] pc4sxt;
    logic        irq_taken;
    logic        exc;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_pc;
    logic        m_pend;
    logic        m_prev;

    pc_next_unit dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .en_i        (en),
        .pcsel_i     (pcsel),
        .lit_i       (lit),
        .jt_i        (jt),
        .irq_i       (irq),
        .pc_o        (pc),
        .pc4_o       (pc4),
        .pc4sxt_o    (pc4sxt),
        .irq_taken_o (irq_taken),
        .exc_o       (exc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] f_pc4(input logic [31:0] p);
        return (p & 32'h8000_0000) | ((p + 32'd4) & 32'h7FFF_FFFF);
    endfunction

    function automatic logic [31:0] f_pc4sxt(input logic [31:0] p, input logic [15:0] l);
        int off;
        off = int'($signed(l)) * 4;
        return (p & 32'h8000_0000) | ((f_pc4(p) + 32'(off)) & 32'h7FFF_FFFF);
    endfunction

    function automatic logic m_pend_eff();
`ifdef PCNEXT_IRQ_LATCH_EN
        return m_pend;
`else
        return irq;
`endif
    endfunction

    function automatic logic m_irq_sel();
        return m_pend_eff() && !m_pc[31];
    endfunction

    function automatic logic m_exc();
        return !rst && (m_irq_sel() || pcsel >= 3'd3);
    endfunction

    function automatic logic m_taken();
        return !rst && en && m_irq_sel();
    endfunction

    function automatic logic [31:0] m_next();
        if (m_irq_sel()) return 32'h8000_0008;
        case (pcsel)
            3'd0: return f_pc4(m_pc);
            3'd1: return f_pc4sxt(m_pc, lit);
            3'd2: return ((m_pc & jt) & 32'h8000_0000) | (jt & 32'h7FFF_FFFC);
            3'd4: return 32'h8000_0008;
            default: return 32'h8000_0004;
        endcase
    endfunction

    task automatic set_in(input logic e, input logic [2:0] s, input logic [15:0] l,
                          input logic [31:0] j, input logic i);
        en = e; pcsel = s; lit = l; jt = j; irq = i;
        #1;
    endtask

    task automatic tick();
        logic [31:0] nxt;
        logic        tk;
        @(posedge clk);
        nxt = m_next();
        tk  = m_taken();
        if (en) m_pc = nxt;
        m_pend = (m_pend && !tk) || (irq && !m_prev);
        m_prev = irq;
        #1;
    endtask

    task automatic model_reset();
        m_pc = 32'h8000_0000; m_pend = 1'b0; m_prev = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        set_in(1'b0, 3'd0, 16'h0, 32'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (pc !== 32'h8000_0000) begin errors++; $display("FAIL reset_pc: got %h want %h", pc, 32'h8000_0000); end
        set_in(1'b1, 3'd2, 16'h0, 32'h0000_0100, 1'b0);
        tick();
        checks++; if (pc !== 32'h0000_0100) begin errors++; $display("FAIL pre_reset_jmp: got %h want %h", pc, 32'h0000_0100); end
        rst = 1'b1;
        set_in(1'b1, 3'd3, 16'h0, 32'h0, 1'b1);
        model_reset();
        checks++; if (pc !== 32'h8000_0000) begin errors++; $display("FAIL midrun_reset_pc: got %h want %h", pc, 32'h8000_0000); end
        checks++; if (exc !== 1'b0) begin errors++; $display("FAIL reset_exc: got %b want 0", exc); end
        checks++; if (irq_taken !== 1'b0) begin errors++; $display("FAIL reset_irq_taken: got %b want 0", irq_taken); end
        @(posedge clk);
        #1;
        checks++; if (pc !== 32'h8000_0000) begin errors++; $display("FAIL reset_overrides_en: got %h want %h", pc, 32'h8000_0000); end
        do_reset();
    endtask

    task automatic test_branch();
        set_in(1'b1, 3'd2, 16'h0, 32'h0000_0100, 1'b0);
        tick();
        set_in(1'b1, 3'd1, 16'hFFFE, 32'h0, 1'b0);
        checks++; if (pc4 !== 32'h0000_0104) begin errors++; $display("FAIL pc4: got %h want %h", pc4, 32'h0000_0104); end
        checks++; if (pc4sxt !== 32'h0000_00FC) begin errors++; $display("FAIL pc4sxt_neg: got %h want %h", pc4sxt, 32'h0000_00FC); end
        checks++; if (exc !== 1'b0) begin errors++; $display("FAIL branch_exc: got %b want 0", exc); end
        tick();
        checks++; if (pc !== 32'h0000_00FC) begin errors++; $display("FAIL branch_pc: got %h want %h", pc, 32'h0000_00FC); end
    endtask

    task automatic test_jmp();
        do_reset();
        set_in(1'b1, 3'd2, 16'h0, 32'h0000_0010, 1'b0);
        tick();
        set_in(1'b1, 3'd2, 16'h0, 32'h8000_0203, 1'b0);
        tick();
        checks++; if (pc !== 32'h0000_0200) begin errors++; $display("FAIL jmp_user_no_sup: got %h want %h", pc, 32'h0000_0200); end
        do_reset();
        set_in(1'b1, 3'd2, 16'h0, 32'h8000_0010, 1'b0);
        tick();
        set_in(1'b1, 3'd2, 16'h0, 32'h8000_0400, 1'b0);
        tick();
        checks++; if (pc !== 32'h8000_0400) begin errors++; $display("FAIL jmp_sup: got %h want %h", pc, 32'h8000_0400); end
    endtask

    task automatic test_wrap();
        do_reset();
        set_in(1'b1, 3'd2, 16'h0, 32'hFFFF_FFFC, 1'b0);
        tick();
        checks++; if (pc4 !== 32'h8000_0000) begin errors++; $display("FAIL wrap_sup_pc4: got %h want %h", pc4, 32'h8000_0000); end
        set_in(1'b1, 3'd2, 16'h0, 32'h7FFF_FFFF, 1'b0);
        tick();
        checks++; if (pc !== 32'h7FFF_FFFC) begin errors++; $display("FAIL jmp_lowbits: got %h want %h", pc, 32'h7FFF_FFFC); end
        checks++; if (pc4 !== 32'h0000_0000) begin errors++; $display("FAIL wrap_user_pc4: got %h want %h", pc4, 32'h0000_0000); end
        set_in(1'b1, 3'd1, 16'h0001, 32'h0, 1'b0);
        checks++; if (pc4sxt !== 32'h0000_0004) begin errors++; $display("FAIL wrap_pc4sxt: got %h want %h", pc4sxt, 32'h0000_0004); end
    endtask

    task automatic test_illop();
        do_reset();
        for (int s = 5; s <= 7; s++) begin
            set_in(1'b1, 3'(s), 16'h0, 32'h0, 1'b0);
            checks++; if (exc !== 1'b1) begin errors++; $display("FAIL illop_exc sel=%0d: got %b want 1", s, exc); end
            tick();
            checks++; if (pc !== 32'h8000_0004) begin errors++; $display("FAIL illop_pc sel=%0d: got %h want %h", s, pc, 32'h8000_0004); end
        end
    endtask

    task automatic test_stall();
        logic [31:0] held;
        do_reset();
        set_in(1'b1, 3'd2, 16'h0, 32'h0000_0080, 1'b0);
        tick();
        held = 32'h0000_0080;
        for (int c = 0; c < 3; c++) begin
            set_in(1'b0, 3'd3, 16'h0, 32'h0, 1'b0);
            checks++; if (exc !== 1'b1) begin errors++; $display("FAIL stall_exc: got %b want 1", exc); end
            checks++; if (irq_taken !== 1'b0) begin errors++; $display("FAIL stall_irq_taken: got %b want 0", irq_taken); end
            tick();
            checks++; if (pc !== held) begin errors++; $display("FAIL stall_pc: got %h want %h", pc, held); end
        end
    endtask

`ifndef PCNEXT_IRQ_LATCH_EN
    task automatic test_irq();
        do_reset();
        set_in(1'b1, 3'd2, 16'h0, 32'h0000_0040, 1'b0);
        tick();
        set_in(1'b1, 3'd1, 16'h0010, 32'h0, 1'b1);
        checks++; if (irq_taken !== 1'b1) begin errors++; $display("FAIL irq_taken: got %b want 1", irq_taken); end
        checks++; if (exc !== 1'b1) begin errors++; $display("FAIL irq_exc: got %b want 1", exc); end
        tick();
        checks++; if (pc !== 32'h8000_0008) begin errors++; $display("FAIL irq_pc: got %h want %h", pc, 32'h8000_0008); end
        set_in(1'b1, 3'd0, 16'h0, 32'h0, 1'b1);
        checks++; if (irq_taken !== 1'b0) begin errors++; $display("FAIL irq_sup_masked: got %b want 0", irq_taken); end
        tick();
        checks++; if (pc !== 32'h8000_000C) begin errors++; $display("FAIL irq_sup_pc: got %h want %h", pc, 32'h8000_000C); end
        set_in(1'b1, 3'd2, 16'h0, 32'h0000_0500, 1'b1);
        tick();
        set_in(1'b0, 3'd0, 16'h0, 32'h0, 1'b1);
        checks++; if (irq_taken !== 1'b0) begin errors++; $display("FAIL irq_stall_taken: got %b want 0", irq_taken); end
        checks++; if (exc !== 1'b1) begin errors++; $display("FAIL irq_stall_exc: got %b want 1", exc); end
        tick();
        set_in(1'b1, 3'd0, 16'h0, 32'h0, 1'b1);
        checks++; if (irq_taken !== 1'b1) begin errors++; $display("FAIL irq_after_sup: got %b want 1", irq_taken); end
        tick();
        checks++; if (pc !== 32'h8000_0008) begin errors++; $display("FAIL irq_after_sup_pc: got %h want %h", pc, 32'h8000_0008); end
    endtask
`else
    task automatic test_irq_latch();
        do_reset();
        set_in(1'b1, 3'd2, 16'h0, 32'h8000_0020, 1'b0);
        tick();
        set_in(1'b1, 3'd2, 16'h0, 32'h0000_0300, 1'b1);
        checks++; if (irq_taken !== 1'b0) begin errors++; $display("FAIL latch_sup_taken: got %b want 0", irq_taken); end
        tick();
        checks++; if (pc !== 32'h0000_0300) begin errors++; $display("FAIL latch_jmp_pc: got %h want %h", pc, 32'h0000_0300); end
        set_in(1'b1, 3'd0, 16'h0, 32'h0, 1'b0);
        checks++; if (irq_taken !== 1'b1) begin errors++; $display("FAIL latch_taken: got %b want 1", irq_taken); end
        tick();
        checks++; if (pc !== 32'h8000_0008) begin errors++; $display("FAIL latch_redirect: got %h want %h", pc, 32'h8000_0008); end
        set_in(1'b1, 3'd7, 16'h0, 32'h0, 1'b0);
        checks++; if (exc !== 1'b1) begin errors++; $display("FAIL latch_sel7_exc: got %b want 1", exc); end
        tick();
        checks++; if (pc !== 32'h8000_0004) begin errors++; $display("FAIL latch_sel7_pc: got %h want %h", pc, 32'h8000_0004); end
        for (int c = 0; c < 3; c++) begin
            set_in(1'b0, 3'd0, 16'h0, 32'h0, 1'b0);
            checks++; if (irq_taken !== 1'b0) begin errors++; $display("FAIL latch_stall_taken: got %b want 0", irq_taken); end
            tick();
            checks++; if (pc !== 32'h8000_0004) begin errors++; $display("FAIL latch_stall_pc: got %h want %h", pc, 32'h8000_0004); end
        end
    endtask
`endif

    task automatic test_random();
        logic [31:0] exp_pc;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            set_in(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 16'($urandom),
                   32'($urandom), ($urandom_range(0, 4) == 0));
            checks++; if (pc4 !== f_pc4(m_pc)) begin errors++; $display("FAIL rnd_pc4 n=%0d: got %h want %h", n, pc4, f_pc4(m_pc)); end
            checks++; if (pc4sxt !== f_pc4sxt(m_pc, lit)) begin errors++; $display("FAIL rnd_pc4sxt n=%0d: got %h want %h", n, pc4sxt, f_pc4sxt(m_pc, lit)); end
            checks++; if (exc !== m_exc()) begin errors++; $display("FAIL rnd_exc n=%0d: got %b want %b", n, exc, m_exc()); end
            checks++; if (irq_taken !== m_taken()) begin errors++; $display("FAIL rnd_taken n=%0d: got %b want %b", n, irq_taken, m_taken()); end
            tick();
            exp_pc = m_pc;
            checks++; if (pc !== exp_pc) begin errors++; $display("FAIL rnd_pc n=%0d: got %h want %h", n, pc, exp_pc); end
        end
    endtask

    initial begin
        rst = 1'b1;
        model_reset();
        en = 1'b0; pcsel = 3'd0; lit = 16'h0; jt = 32'h0; irq = 1'b0;
        test_reset();
        test_branch();
        test_jmp();
        test_wrap();
        test_illop();
        test_stall();
`ifndef PCNEXT_IRQ_LATCH_EN
        test_irq();
`else
        test_irq_latch();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
